// File: rtl/pmp_seq_checker_pkg.sv
// +------------------------------------------------------------------+
// | pmp_seq_checker_pkg: shared types and helpers for the PMP checker |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

package pmp_seq_checker_pkg;

  // pmpcfg address-matching modes (A field, bits [4:3])
  localparam logic [1:0] ADR_OFF   = 2'b00;
  localparam logic [1:0] ADR_TOR   = 2'b01;
  localparam logic [1:0] ADR_NA4   = 2'b10;
  localparam logic [1:0] ADR_NAPOT = 2'b11;

  localparam int CFG_R = 0;
  localparam int CFG_W = 1;
  localparam int CFG_X = 2;
  localparam int CFG_L = 7;

  typedef enum logic [1:0] {
    ACC_READ  = 2'b00,
    ACC_WRITE = 2'b01,
    ACC_EXEC  = 2'b10,
    ACC_RSVD  = 2'b11
  } acc_type_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SCAN = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  // Reserved access type falls through to the read permission.
  function automatic logic perm_ok(input logic [7:0] cfg, input acc_type_e acc);
    logic ok;
    case (acc)
      ACC_WRITE: ok = cfg[CFG_W];
      ACC_EXEC:  ok = cfg[CFG_X];
      default:   ok = cfg[CFG_R];
    endcase
    return ok;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pmp_seq_checker_adrdec.sv
// +------------------------------------------------------------------+
// | pmp_seq_checker_adrdec: single-entry PMP address decoder          |
// | (pmpadrdec) with TOR lower-bound chaining. Rev 1.0                |
// +------------------------------------------------------------------+
`default_nettype none

module pmp_seq_checker_adrdec
  import pmp_seq_checker_pkg::*;
#(
  parameter int PA_BITS = 56,
  parameter int XLEN    = 64
) (
  input  logic [PA_BITS-1:0] pa,
  input  logic [1:0]         size,
  input  logic [1:0]         mode,
  input  logic [XLEN-1:0]    adr,
  input  logic               ge_in,
  output logic               ge_out,
  output logic               match
);

  logic [PA_BITS-1:0] w_base;
  logic [PA_BITS-1:0] w_mask;
  logic               w_lt;
  logic               w_napot;
  logic               w_na4;
  logic               w_run;
  logic               w_na_match;

  assign w_base  = {adr[PA_BITS-3:0], 2'b00};
  assign w_lt    = (pa < w_base);
  assign ge_out  = ~w_lt;
  assign w_napot = (mode == ADR_NAPOT);
  assign w_na4   = (mode == ADR_NA4);

  // NAPOT mask grows through the run of trailing ones in pmpaddr; an
  // 8-byte access against NA4 ignores PA bit 2 (doubleword granularity).
  always_comb begin
    w_mask      = '0;
    w_run       = 1'b1;
    w_mask[1:0] = 2'b11;
    w_mask[2]   = w_napot | (w_na4 & (size == 2'd3));
    for (int i = 3; i < PA_BITS; i++) begin
      w_run     = w_run & adr[i-3];
      w_mask[i] = w_napot & w_run;
    end
  end

  assign w_na_match = (((pa ^ w_base) & ~w_mask) == '0);

  always_comb begin
    case (mode)
      ADR_TOR:   match = ge_in & w_lt;
      ADR_NA4:   match = w_na_match;
      ADR_NAPOT: match = w_na_match;
      default:   match = 1'b0;
    endcase
  end

  generate
    if (XLEN > PA_BITS - 2) begin : g_unused_hi
      logic w_unused_adr;
      assign w_unused_adr = ^adr[XLEN-1:PA_BITS-2];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/pmp_seq_checker.sv
// +------------------------------------------------------------------+
// | pmp_seq_checker: serialized PMP permission checker, one entry per |
// | cycle through a shared decoder. Rev 1.0                           |
// +------------------------------------------------------------------+
`default_nettype none

module pmp_seq_checker
  import pmp_seq_checker_pkg::*;
#(
  parameter int PA_BITS     = 56,
  parameter int XLEN        = 64,
  parameter int PMP_ENTRIES = 16
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [PA_BITS-1:0]          req_pa,
  input  logic [1:0]                  req_size,
  input  logic [1:0]                  req_type,
  input  logic                        req_priv_m,
  input  logic [8*PMP_ENTRIES-1:0]    pmpcfg,
  input  logic [XLEN*PMP_ENTRIES-1:0] pmpaddr,
  output logic                        busy,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic                        rsp_fault,
  output logic [5:0]                  rsp_index,
  output logic                        rsp_hit
);

  localparam int             IW       = $clog2(PMP_ENTRIES) + 1;
  localparam int             NSLOT    = 2 ** IW;
  localparam logic [IW-1:0]  LAST_IDX = IW'(PMP_ENTRIES - 1);

  // Entry table padded to a power of two so the scan index selects exactly.
  logic [7:0]      w_cfg_arr [NSLOT];
  logic [XLEN-1:0] w_adr_arr [NSLOT];

  generate
    for (genvar gi = 0; gi < NSLOT; gi++) begin : g_entry
      if (gi < PMP_ENTRIES) begin : g_live
        assign w_cfg_arr[gi] = pmpcfg[8*gi +: 8];
        assign w_adr_arr[gi] = pmpaddr[XLEN*gi +: XLEN];
      end else begin : g_pad
        assign w_cfg_arr[gi] = 8'h00;
        assign w_adr_arr[gi] = '0;
      end
    end
  endgenerate

  state_e             r_state;
  logic [IW-1:0]      r_idx;
  logic               r_ge;
  logic [PA_BITS-1:0] r_pa;
  logic [1:0]         r_size;
  acc_type_e          r_type;
  logic               r_priv_m;
  logic               r_req_ready;
  logic               r_busy;
  logic               r_rsp_valid;
  logic               r_fault;
  logic               r_hit;
  logic [5:0]         r_index;

  logic [7:0]         w_cfg_cur;
  logic [XLEN-1:0]    w_adr_cur;
  logic               w_ge_out;
  logic               w_match;
  logic               w_hit_fault;

  assign w_cfg_cur = w_cfg_arr[r_idx];
  assign w_adr_cur = w_adr_arr[r_idx];

  pmp_seq_checker_adrdec #(
    .PA_BITS (PA_BITS),
    .XLEN    (XLEN)
  ) u_adrdec (
    .pa     (r_pa),
    .size   (r_size),
    .mode   (w_cfg_cur[4:3]),
    .adr    (w_adr_cur),
    .ge_in  (r_ge),
    .ge_out (w_ge_out),
    .match  (w_match)
  );

  // Unlocked entries never restrict machine mode.
  assign w_hit_fault = ~(r_priv_m & ~w_cfg_cur[CFG_L]) & ~perm_ok(w_cfg_cur, r_type);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_ge        <= 1'b1;
      r_pa        <= '0;
      r_size      <= 2'd0;
      r_type      <= ACC_READ;
      r_priv_m    <= 1'b0;
      r_req_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_fault     <= 1'b0;
      r_hit       <= 1'b0;
      r_index     <= 6'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_pa        <= req_pa;
            r_size      <= req_size;
            r_type      <= acc_type_e'(req_type);
            r_priv_m    <= req_priv_m;
            r_idx       <= '0;
            r_ge        <= 1'b1;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          r_ge <= w_ge_out;
          if (w_match) begin
            r_hit       <= 1'b1;
            r_index     <= 6'(r_idx);
            r_fault     <= w_hit_fault;
            r_busy      <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
          end else if (r_idx == LAST_IDX) begin
            r_hit       <= 1'b0;
            r_index     <= 6'd0;
            r_fault     <= ~r_priv_m;
            r_busy      <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_req_ready <= 1'b1;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign busy      = r_busy;
  assign rsp_valid = r_rsp_valid;
  assign rsp_fault = r_fault;
  assign rsp_hit   = r_hit;
  assign rsp_index = r_index;

endmodule

`default_nettype wire

// File: tb/tb_pmp_seq_checker.sv
// +------------------------------------------------------------------+
// | tb_pmp_seq_checker: directed table, corner sequences and random   |
// | requests against a region-based reference model. Rev 1.0          |
// +------------------------------------------------------------------+
`default_nettype none

module tb_pmp_seq_checker;

  localparam int N  = 16;
  localparam int PA = 56;
  localparam int XL = 64;
  localparam logic [63:0] MASK54 = 64'h003F_FFFF_FFFF_FFFF;

  logic            clk;
  logic            reset_n;
  logic            req_valid;
  logic            req_ready;
  logic [PA-1:0]   req_pa;
  logic [1:0]      req_size;
  logic [1:0]      req_type;
  logic            req_priv_m;
  logic [8*N-1:0]  pmpcfg;
  logic [XL*N-1:0] pmpaddr;
  logic            busy;
  logic            rsp_valid;
  logic            rsp_ready;
  logic            rsp_fault;
  logic [5:0]      rsp_index;
  logic            rsp_hit;

  logic [7:0]  cfg_m [N];
  logic [63:0] adr_m [N];

  int n_pass;
  int n_total;

  pmp_seq_checker #(.PA_BITS(PA), .XLEN(XL), .PMP_ENTRIES(N)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_pa     (req_pa),
    .req_size   (req_size),
    .req_type   (req_type),
    .req_priv_m (req_priv_m),
    .pmpcfg     (pmpcfg),
    .pmpaddr    (pmpaddr),
    .busy       (busy),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_fault  (rsp_fault),
    .rsp_index  (rsp_index),
    .rsp_hit    (rsp_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    pmpcfg  = '0;
    pmpaddr = '0;
    for (int i = 0; i < N; i++) begin
      pmpcfg[8*i +: 8]    = cfg_m[i];
      pmpaddr[XL*i +: XL] = adr_m[i];
    end
  end

  typedef struct {
    int          sel;
    logic [55:0] pa;
    logic [1:0]  size;
    logic [1:0]  typ;
    logic        priv;
    logic        hit;
    int          idx;
    logic        fault;
    int          lat;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    else
      n_pass++;
  endtask

  task automatic load_cfg(input int sel);
    for (int i = 0; i < N; i++) begin
      cfg_m[i] = 8'h00;
      adr_m[i] = 64'h0;
    end
    case (sel)
      1: begin adr_m[0] = 64'h2000_0000; cfg_m[0] = 8'h0B; end
      2: begin
        adr_m[3] = 64'h0400_01FF; cfg_m[3] = 8'h1C;
        adr_m[5] = 64'h0400_01FF; cfg_m[5] = 8'h1F;
      end
      3: begin adr_m[2] = 64'h40; cfg_m[2] = 8'h99; end
      4: begin adr_m[2] = 64'h40; cfg_m[2] = 8'h19; end
      default: ;
    endcase
  endtask

  // Reference: each entry is an address range; first covering active entry wins.
  function automatic void model(input logic [55:0] pa, input logic [1:0] sz, input logic [1:0] typ,
                                input logic priv, output logic hit, output int idx, output logic fault);
    logic [63:0] p, a, lo, hi, span;
    logic        m;
    int          t;
    logic [7:0]  c;
    hit = 1'b0;
    idx = 0;
    p   = {8'h00, pa};
    for (int i = 0; i < N; i++) begin
      a = adr_m[i] & MASK54;
      m = 1'b0;
      case (cfg_m[i][4:3])
        2'b01: begin
          lo = 64'h0;
          if (i > 0) lo = (adr_m[i-1] & MASK54) << 2;
          hi = a << 2;
          m  = (p >= lo) && (p < hi);
        end
        2'b10: begin
          lo = a << 2;
          if (sz == 2'd3) m = ((p >> 3) == (lo >> 3));
          else            m = ((p >> 2) == (lo >> 2));
        end
        2'b11: begin
          t = 0;
          while (t < 54 && a[t]) t++;
          span = 64'h1 << (t + 3);
          lo   = (a << 2) & ~(span - 64'h1);
          m    = (p >= lo) && (p < lo + span);
        end
        default: m = 1'b0;
      endcase
      if (m && !hit) begin
        hit = 1'b1;
        idx = i;
      end
    end
    if (hit) begin
      c = cfg_m[idx];
      if (priv && !c[7])      fault = 1'b0;
      else if (typ == 2'd1)   fault = ~c[1];
      else if (typ == 2'd2)   fault = ~c[2];
      else                    fault = ~c[0];
    end else begin
      fault = ~priv;
    end
  endfunction

  // Starts just after a negedge; returns just after a negedge.
  task automatic do_req(input logic [55:0] pa, input logic [1:0] sz, input logic [1:0] typ,
                        input logic priv, input bit consume,
                        output logic o_hit, output int o_idx, output logic o_fault,
                        output int o_lat, output bit o_ok);
    int guard;
    guard = 0;
    o_ok  = 1'b0;
    o_lat = 0;
    o_hit = 1'b0; o_idx = 0; o_fault = 1'b0;
    while (!req_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      n_total++;
      $display("FAIL req_ready_wait actual=0 required=1");
      return;
    end
    req_valid  = 1'b1;
    req_pa     = pa;
    req_size   = sz;
    req_type   = typ;
    req_priv_m = priv;
    @(posedge clk);
    for (int c = 1; c <= N + 20; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (rsp_valid) begin
        o_lat = c;
        o_ok  = 1'b1;
        break;
      end
    end
    if (!o_ok) begin
      n_total++;
      $display("FAIL rsp_timeout actual=no_rsp required=rsp_valid");
      return;
    end
    o_hit   = rsp_hit;
    o_idx   = int'(rsp_index);
    o_fault = rsp_fault;
    if (consume) begin
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check("ready_after_rsp", 64'(req_ready), 64'h1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        g_hit, g_fault, e_hit, e_fault;
    int          g_idx, g_lat, e_idx;
    bit          ok;
    logic [55:0] pa;
    int          sz;
    int unsigned a, base, t, mode;

    n_pass = 0; n_total = 0;
    reset_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_pa = '0; req_size = 2'd0; req_type = 2'd0; req_priv_m = 1'b0;
    load_cfg(0);

    vecs[0]  = '{0, 56'h8000_0000, 2'd2, 2'd0, 1'b0, 1'b0, 0, 1'b1, N + 1};
    vecs[1]  = '{0, 56'h8000_0000, 2'd2, 2'd0, 1'b1, 1'b0, 0, 1'b0, N + 1};
    vecs[2]  = '{1, 56'h7FFF_FFF8, 2'd3, 2'd1, 1'b0, 1'b1, 0, 1'b0, 2};
    vecs[3]  = '{1, 56'h8000_0000, 2'd3, 2'd1, 1'b0, 1'b0, 0, 1'b1, N + 1};
    vecs[4]  = '{1, 56'h7FFF_FFF8, 2'd2, 2'd2, 1'b0, 1'b1, 0, 1'b1, 2};
    vecs[5]  = '{1, 56'h0,         2'd0, 2'd3, 1'b0, 1'b1, 0, 1'b0, 2};
    vecs[6]  = '{2, 56'h1000_0010, 2'd2, 2'd0, 1'b0, 1'b1, 3, 1'b1, 5};
    vecs[7]  = '{2, 56'h1000_0010, 2'd2, 2'd2, 1'b0, 1'b1, 3, 1'b0, 5};
    vecs[8]  = '{2, 56'h1000_1000, 2'd2, 2'd0, 1'b0, 1'b0, 0, 1'b1, N + 1};
    vecs[9]  = '{2, 56'h1000_0FFC, 2'd2, 2'd0, 1'b1, 1'b1, 3, 1'b0, 5};
    vecs[10] = '{3, 56'h100,       2'd2, 2'd1, 1'b1, 1'b1, 2, 1'b1, 4};
    vecs[11] = '{3, 56'h100,       2'd2, 2'd0, 1'b1, 1'b1, 2, 1'b0, 4};
    vecs[12] = '{4, 56'h100,       2'd2, 2'd1, 1'b1, 1'b1, 2, 1'b0, 4};
    vecs[13] = '{3, 56'h108,       2'd2, 2'd1, 1'b1, 1'b0, 0, 1'b0, N + 1};

    repeat (3) @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'h1);
    check("rst_busy",      64'(busy),      64'h0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    check("rst_rsp_fault", 64'(rsp_fault), 64'h0);
    check("rst_rsp_hit",   64'(rsp_hit),   64'h0);
    check("rst_rsp_index", 64'(rsp_index), 64'h0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 14; v++) begin
      load_cfg(vecs[v].sel);
      do_req(vecs[v].pa, vecs[v].size, vecs[v].typ, vecs[v].priv, 1'b1, g_hit, g_idx, g_fault, g_lat, ok);
      if (ok) begin
        check($sformatf("vec%0d_hit", v),   64'(g_hit),   64'(vecs[v].hit));
        check($sformatf("vec%0d_fault", v), 64'(g_fault), 64'(vecs[v].fault));
        check($sformatf("vec%0d_lat", v),   64'(g_lat),   64'(vecs[v].lat));
        if (vecs[v].hit)
          check($sformatf("vec%0d_idx", v), 64'(g_idx), 64'(vecs[v].idx));
      end
    end

    // Backpressure: response held stable while the consumer stalls.
    load_cfg(2);
    do_req(56'h1000_0010, 2'd2, 2'd0, 1'b0, 1'b0, g_hit, g_idx, g_fault, g_lat, ok);
    if (ok) begin
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        check("stall_rsp_valid", 64'(rsp_valid), 64'h1);
        check("stall_req_ready", 64'(req_ready), 64'h0);
        check("stall_index",     64'(rsp_index), 64'h3);
        check("stall_fault",     64'(rsp_fault), 64'h1);
        check("stall_hit",       64'(rsp_hit),   64'h1);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check("stall_release_valid", 64'(rsp_valid), 64'h0);
      check("stall_release_ready", 64'(req_ready), 64'h1);
    end

    // Reset in the middle of a scan aborts it.
    load_cfg(0);
    req_valid = 1'b1; req_pa = 56'h8000_0000; req_size = 2'd2; req_type = 2'd0; req_priv_m = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("midscan_busy", 64'(busy), 64'h1);
    reset_n = 1'b0;
    #1;
    check("abort_rsp_valid", 64'(rsp_valid), 64'h0);
    check("abort_req_ready", 64'(req_ready), 64'h1);
    check("abort_busy",      64'(busy),      64'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    load_cfg(2);
    do_req(56'h1000_0010, 2'd2, 2'd0, 1'b0, 1'b1, g_hit, g_idx, g_fault, g_lat, ok);
    if (ok) begin
      check("post_rst_idx", 64'(g_idx), 64'h3);
      check("post_rst_lat", 64'(g_lat), 64'h5);
    end

    // Random configurations and requests against the reference model.
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < N; i++) begin
        mode = $urandom_range(0, 3);
        cfg_m[i] = {($urandom_range(0, 3) == 0), 2'b00, 2'(mode), 3'($urandom_range(0, 7))};
        base = $urandom_range(0, 32'h3FFF);
        if (mode == 3) begin
          t = $urandom_range(0, 8);
          a = (base & ~((32'd2 << t) - 1)) | ((32'd1 << t) - 1);
        end else begin
          a = base;
        end
        adr_m[i] = 64'(a);
      end
      for (int q = 0; q < 20; q++) begin
        sz = $urandom_range(0, 3);
        pa = 56'($urandom_range(0, 32'hFFFF)) & ~56'((1 << sz) - 1);
        if ($urandom_range(0, 7) == 0) pa[40] = 1'b1;
        req_type   = 2'($urandom_range(0, 3));
        req_priv_m = 1'($urandom_range(0, 1));
        model(pa, 2'(sz), req_type, req_priv_m, e_hit, e_idx, e_fault);
        do_req(pa, 2'(sz), req_type, req_priv_m, 1'b1, g_hit, g_idx, g_fault, g_lat, ok);
        if (ok) begin
          check("rnd_hit",   64'(g_hit),   64'(e_hit));
          check("rnd_fault", 64'(g_fault), 64'(e_fault));
          check("rnd_lat",   64'(g_lat),   e_hit ? 64'(e_idx + 2) : 64'(N + 1));
          if (e_hit) check("rnd_idx", 64'(g_idx), 64'(e_idx));
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
